// File: rtl/ucore_main.sv
// Iterative 64-bit Fibonacci engine: one addition per cycle, done rises n+2 edges after acceptance.
// The host holds valid until it sees done. done then holds until valid drops, and a new request is accepted only after that.
module ucore_main (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [7:0]  n,
  input  logic        valid,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] a;
  logic [63:0] b;
  logic [7:0]  count;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      done   <= 1'b0;
      result <= 64'd0;
      a      <= 64'd0;
      b      <= 64'd0;
      count  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            a     <= 64'd0;
            b     <= 64'd1;
            count <= n;
            state <= LOOP;
          end
        end
        LOOP: begin
          // After k iterations a holds F(k); carry-out past bit 63 is dropped.
          if (count != 8'd0) begin
            a     <= b;
            b     <= a + b;
            count <= count - 8'd1;
          end else begin
            result <= a;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!valid) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ucore_main.sv
// Directed bench for ucore_main: reset, latency, wrap, handshake, sweep and mid-run reset.
module tb_ucore_main;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  n = 8'd0;
  logic        valid = 1'b0;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ucore_main dut (
    .clk    (clk),
    .aresetn(aresetn),
    .n      (n),
    .valid  (valid),
    .done   (done),
    .result (result)
  );

  function automatic logic [63:0] fib(input int k);
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] t;
    x = 64'd0;
    y = 64'd1;
    for (int i = 0; i < k; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Raise valid with index nn and count rising edges until done (bounded).
  task automatic start_req(input logic [7:0] nn, output int edges);
    @(negedge clk);
    n = nn;
    valid = 1'b1;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 400);
  endtask

  task automatic release_req(input string tag);
    @(negedge clk);
    valid = 1'b0;
    @(posedge clk);
    #1;
    check(tag, {63'd0, done}, 64'd0);
  endtask

  task automatic full_req(input logic [7:0] nn, input logic [63:0] exp, input string tag);
    int edges;
    start_req(nn, edges);
    check({tag, "_latency"}, 64'(edges), 64'(int'(nn) + 2));
    check({tag, "_result"}, result, exp);
    release_req({tag, "_release"});
  endtask

  initial begin
    int edges;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk);
    aresetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_done", {63'd0, done}, 64'd0);
    check("idle_result", result, 64'd0);

    // Basic values with hand-computed results and latencies.
    full_req(8'd1, 64'd1, "n1");
    full_req(8'd10, 64'd55, "n10");
    full_req(8'd0, 64'd0, "n0");
    full_req(8'd93, 64'd12200160415121876738, "n93");
    full_req(8'd94, 64'd1293530146158671551, "n94");

    // Hold valid after done; n changes must be ignored.
    start_req(8'd10, edges);
    check("hold_latency", 64'(edges), 64'd12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n = 8'(i + 3);
      @(posedge clk);
      #1;
      check("hold_done", {63'd0, done}, 64'd1);
      check("hold_result", result, 64'd55);
    end
    release_req("hold_release");
    check("hold_result_after", result, 64'd55);

    // valid dropped mid-LOOP gives a single-cycle done pulse.
    @(negedge clk);
    n = 8'd30;
    valid = 1'b1;
    repeat (5) @(negedge clk);
    valid = 1'b0;
    n = 8'd3;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!done && edges < 400);
    check("drop_pulse_high", {63'd0, done}, 64'd1);
    check("drop_result", result, 64'd832040);
    @(posedge clk);
    #1;
    check("drop_pulse_low", {63'd0, done}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("drop_stays_idle", {63'd0, done}, 64'd0);

    // Sweep against the reference model.
    for (int k = 1; k <= 254; k++) begin
      repeat (5) @(posedge clk);
      #1;
      check("sweep_pre_done", {63'd0, done}, 64'd0);
      start_req(8'(k), edges);
      check("sweep_latency", 64'(edges), 64'(k + 2));
      check("sweep_result", result, fib(k));
      @(negedge clk);
      valid = 1'b0;
    end
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a long computation.
    @(negedge clk);
    n = 8'd200;
    valid = 1'b1;
    repeat (50) @(posedge clk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_result", result, 64'd0);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_idle", {63'd0, done}, 64'd0);
    full_req(8'd20, 64'd6765, "n20");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
